// File: rtl/fp_normalize_round_pkg.sv
// Shared constants for the binary32 normalize/round pipeline.
// Flag bit positions match out_flags = {overflow, underflow, inexact, zero}.
package fp_normalize_round_pkg;

  localparam int FP_BIAS    = 127;
  localparam int FP_EXP_MAX = 255;

  localparam logic [7:0] FP_EXP_INF = 8'hFF;

  localparam int FLG_OVF  = 3;
  localparam int FLG_UNF  = 2;
  localparam int FLG_INX  = 1;
  localparam int FLG_ZERO = 0;

  localparam logic [5:0] ZERO_SHIFT = 6'd49;

  typedef struct packed {
    logic ovf;
    logic unf;
    logic inx;
    logic zero;
  } fp_flags_t;

endpackage

// File: rtl/fp32_round_pack.sv
// Round-to-nearest-even, exponent fix-up and binary32 packing.
// Purely combinational; the caller registers the result.
module fp32_round_pack
  import fp_normalize_round_pkg::*;
#(
  parameter int EXP_W = 10
) (
  input  logic           i_sign,
  input  logic [47:0]    i_norm,
  input  logic [EXP_W:0] i_exp,
  input  logic           i_zero,
  output logic [31:0]    o_data,
  output logic [3:0]     o_flags
);

  localparam int EW = EXP_W + 2;

  localparam logic signed [EW-1:0] W_MAX = EW'(FP_EXP_MAX);
  localparam logic signed [EW-1:0] W_MIN = '0;

  logic [23:0]          w_mant;
  logic                 w_guard;
  logic                 w_sticky;
  logic                 w_up;
  logic [24:0]          w_sum;
  logic [23:0]          w_mfin;
  logic signed [EW-1:0] w_exp;
  logic                 w_ovf;
  logic                 w_unf;
  fp_flags_t            w_flg;

  assign w_mant   = i_norm[47:24];
  assign w_guard  = i_norm[23];
  assign w_sticky = |i_norm[22:0];
  assign w_up     = w_guard & (w_sticky | w_mant[0]);
  assign w_sum    = {1'b0, w_mant} + {24'd0, w_up};
  assign w_mfin   = w_sum[24] ? 24'h800000 : w_sum[23:0];

  // Carry out of the significand bumps the exponent by one.
  assign w_exp = $signed({i_exp[EXP_W], i_exp})
               + $signed({{(EW-1){1'b0}}, w_sum[24]});

  assign w_ovf = !i_zero && (w_exp >= W_MAX);
  assign w_unf = !i_zero && (w_exp <= W_MIN);

  always_comb begin
    w_flg  = '0;
    o_data = {i_sign, w_exp[7:0], w_mfin[22:0]};
    unique case (1'b1)
      i_zero: begin
        o_data     = {i_sign, 31'd0};
        w_flg.zero = 1'b1;
      end
      w_ovf: begin
        o_data    = {i_sign, FP_EXP_INF, 23'd0};
        w_flg.ovf = 1'b1;
        w_flg.inx = 1'b1;
      end
      w_unf: begin
        o_data    = {i_sign, 31'd0};
        w_flg.unf = 1'b1;
        w_flg.inx = 1'b1;
      end
      default: w_flg.inx = w_guard | w_sticky;
    endcase
  end

  always_comb begin
    o_flags           = '0;
    o_flags[FLG_OVF]  = w_flg.ovf;
    o_flags[FLG_UNF]  = w_flg.unf;
    o_flags[FLG_INX]  = w_flg.inx;
    o_flags[FLG_ZERO] = w_flg.zero;
  end

endmodule

// File: rtl/fp_normalize_round.sv
// Two-stage elastic normalize + round pipeline for a binary32 product.
// Stage 1 normalizes the raw significand; stage 2 holds the packed result.
module fp_normalize_round
  import fp_normalize_round_pkg::*;
#(
  parameter int EXP_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [47:0]      in_mant,
  input  logic [5:0]       in_shift,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [3:0]       out_flags,
  output logic [15:0]      out_count
);

  logic           r_run;
  logic           r_s1_v;
  logic           r_s1_sign;
  logic           r_s1_zero;
  logic [47:0]    r_s1_norm;
  logic [EXP_W:0] r_s1_exp;

  logic           w_s2_ld;
  logic           w_s1_ld;
  logic           w_acc;
  logic [5:0]     w_lz;
  logic [47:0]    w_norm;
  logic [EXP_W:0] w_e1;
  logic           w_zero;
  logic [31:0]    w_data;
  logic [3:0]     w_flags;

  assign w_s2_ld  = !out_valid | out_ready;
  assign w_s1_ld  = !r_s1_v | w_s2_ld;
  // r_run keeps the input closed until the first edge after reset.
  assign in_ready = r_run & w_s1_ld;
  assign w_acc    = in_valid & in_ready;

  assign w_lz   = in_shift - 6'd1;
  assign w_norm = in_mant << w_lz;
  assign w_e1   = {in_exp[EXP_W-1], in_exp}
                + (EXP_W+1)'(1)
                - (EXP_W+1)'(w_lz);
  assign w_zero = (in_shift == 6'd0) | (in_shift >= ZERO_SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run     <= 1'b0;
      r_s1_v    <= 1'b0;
      r_s1_sign <= 1'b0;
      r_s1_zero <= 1'b0;
      r_s1_norm <= '0;
      r_s1_exp  <= '0;
    end else begin
      r_run <= 1'b1;
      if (w_s1_ld) r_s1_v <= w_acc;
      if (w_acc) begin
        r_s1_sign <= in_sign;
        r_s1_zero <= w_zero;
        r_s1_norm <= w_norm;
        r_s1_exp  <= w_e1;
      end
    end
  end

  fp32_round_pack #(
    .EXP_W (EXP_W)
  ) u_round (
    .i_sign  (r_s1_sign),
    .i_norm  (r_s1_norm),
    .i_exp   (r_s1_exp),
    .i_zero  (r_s1_zero),
    .o_data  (w_data),
    .o_flags (w_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_flags <= '0;
      out_count <= '0;
    end else begin
      if (w_s2_ld) begin
        out_valid <= r_s1_v;
        if (r_s1_v) begin
          out_data  <= w_data;
          out_flags <= w_flags;
        end
      end
      if (out_valid && out_ready) out_count <= out_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fp_normalize_round.sv
// Randomized bench for fp_normalize_round with an arithmetic reference
// model and an in-order scoreboard.
module tb_fp_normalize_round;
  import fp_normalize_round_pkg::*;

  typedef struct {
    logic        sign;
    int          exp;
    logic [47:0] mant;
    logic [5:0]  shift;
  } beat_t;

  typedef struct {
    logic [35:0] exp;
    int          cyc;
    int          stl;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [9:0]  in_exp = '0;
  logic [47:0] in_mant = '0;
  logic [5:0]  in_shift = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  out_flags;
  logic [15:0] out_count;

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          stalls = 0;
  logic [15:0] n_out = '0;
  sb_t         sb[$];
  logic        ovr_v = 1'b0;
  logic [35:0] ovr_val = '0;
  bit          rdone = 1'b0;

  fp_normalize_round #(
    .EXP_W (10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .in_shift  (in_shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flags (out_flags),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(string tag, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Value = mant * 2^(exp-127-46); round the 24-bit significand by remainder.
  function automatic logic [35:0] ref_model(beat_t b);
    longint m, sig, rem, half;
    int     p, k, be;
    logic   inx, up;
    if (b.shift == 6'd0 || b.shift >= 6'd49)
      return {b.sign, 31'd0, 4'b0001};
    m = longint'(b.mant);
    p = 0;
    for (int i = 0; i < 48; i++)
      if (b.mant[i]) p = i;
    be = (b.exp - FP_BIAS) + (p - 46) + FP_BIAS;
    if (p >= 23) begin
      k    = p - 23;
      sig  = m >> k;
      rem  = m - (sig << k);
      half = (k == 0) ? 64'sd0 : (64'sd1 << (k - 1));
      inx  = (rem != 0);
      up   = (k > 0) && ((rem > half) || (rem == half && sig[0]));
    end else begin
      sig = m << (23 - p);
      inx = 1'b0;
      up  = 1'b0;
    end
    if (up) sig++;
    if (sig == (64'sd1 << 24)) begin
      sig = sig >> 1;
      be++;
    end
    if (be >= 255) return {b.sign, 8'hFF, 23'd0, 4'b1010};
    if (be <= 0) return {b.sign, 31'd0, 4'b0110};
    return {b.sign, 8'(be), 23'(sig), 2'b00, inx, 1'b0};
  endfunction

  function automatic beat_t mk(logic s, int e, logic [47:0] m);
    beat_t b;
    b.sign  = s;
    b.exp   = e;
    b.mant  = m;
    b.shift = 6'd49;
    for (int i = 0; i < 48; i++)
      if (m[i]) b.shift = 6'(48 - i);
    return b;
  endfunction

  function automatic beat_t rnd_beat();
    logic [47:0] m;
    int          p, e, r;
    beat_t       b;
    m = 48'({$urandom(), $urandom()});
    r = int'($urandom_range(0, 15));
    case ($urandom_range(0, 3))
      0: e = int'($urandom_range(0, 1023)) - 512;
      1: e = int'($urandom_range(0, 30)) - 10;
      2: e = int'($urandom_range(230, 270));
      default: e = int'($urandom_range(90, 170));
    endcase
    if (r == 1) begin
      m = '0;
    end else if (r >= 2) begin
      p = int'($urandom_range(0, 47));
      m = m & ((48'd1 << p) - 48'd1);
      m[p] = 1'b1;
      if (r == 2 && p >= 24) begin
        m = m & ~((48'd1 << (p - 23)) - 48'd1);
        m[p-24] = 1'b1;
      end
    end
    b = mk(1'($urandom_range(0, 1)), e, m);
    if (r == 0)
      b.shift = ($urandom_range(0, 1) != 0) ? 6'd0 : 6'($urandom_range(50, 63));
    return b;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 64'(out_valid), 64'd0);
        end else begin
          check("data", 64'(out_data), 64'(sb[0].exp[35:4]));
          check("flags", 64'(out_flags), 64'(sb[0].exp[3:0]));
          if (out_ready) begin
            check("count", 64'(out_count), 64'(n_out));
            if (stalls == sb[0].stl)
              check("latency", 64'(cyc - sb[0].cyc), 64'd2);
            void'(sb.pop_front());
            n_out++;
          end else begin
            stalls++;
          end
        end
      end
      if (in_valid && in_ready) begin
        beat_t c;
        sb_t   e;
        c.sign  = in_sign;
        c.exp   = int'($signed(in_exp));
        c.mant  = in_mant;
        c.shift = in_shift;
        e.exp   = ovr_v ? ovr_val : ref_model(c);
        e.cyc   = cyc;
        e.stl   = stalls;
        ovr_v   = 1'b0;
        sb.push_back(e);
      end
    end
  end

  task automatic send(beat_t b);
    int n = 0;
    in_valid = 1'b1;
    in_sign  = b.sign;
    in_exp   = 10'(b.exp);
    in_mant  = b.mant;
    in_shift = b.shift;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  task automatic send_exp(beat_t b, logic [31:0] d, logic [3:0] f);
    ovr_val = {d, f};
    ovr_v   = 1'b1;
    send(b);
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #2;
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_flags", 64'(out_flags), 64'd0);
    check("rst_out_count", 64'(out_count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    sb.delete();
    n_out  = '0;
    ovr_v  = 1'b0;
    stalls = 0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("rdy_before_edge", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    check("rdy_after_edge", 64'(in_ready), 64'd1);
    #1;
  endtask

  initial begin
    #1;
    do_reset();
    out_ready = 1'b1;

    send_exp(mk(1'b0, 127, 48'h400000000000), 32'h3F800000, 4'b0000);
    send_exp(mk(1'b0, 127, 48'h900000000000), 32'h40100000, 4'b0000);
    send_exp(mk(1'b0, 127, 48'h800000800000), 32'h40000000, 4'b0010);
    send_exp(mk(1'b0, 127, 48'h800001800000), 32'h40000002, 4'b0010);
    send_exp(mk(1'b1, 300, 48'h800000000000), 32'hFF800000, 4'b1010);
    send_exp(mk(1'b0, -20, 48'h800000000000), 32'h00000000, 4'b0110);
    send_exp(mk(1'b0, 127, 48'h000000000000), 32'h00000000, 4'b0001);
    begin
      beat_t z;
      z = mk(1'b1, 127, 48'h123456789ABC);
      z.shift = 6'd0;
      send_exp(z, 32'h80000000, 4'b0001);
      z.shift = 6'd63;
      send_exp(z, 32'h80000000, 4'b0001);
    end
    drain();

    do_reset();
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(mk(1'b0, 127 + i, 48'hC00000000000));
      end
      begin
        repeat (4) @(negedge clk);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        repeat (2) @(posedge clk);
        #2;
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", 64'(out_count), 64'd4);

    rdone = 1'b0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #2;
          end else begin
            send(rnd_beat());
          end
        end
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          @(posedge clk);
          #2;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();
    check("rand_count", 64'(out_count), 64'(n_out));

    out_ready = 1'b0;
    send(rnd_beat());
    send(rnd_beat());
    check("full_valid", 64'(out_valid), 64'd1);
    check("full_ready", 64'(in_ready), 64'd0);
    #1;
    do_reset();
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    for (int i = 0; i < 6; i++) send(rnd_beat());
    drain();
    check("post_rst_count", 64'(out_count), 64'd6);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fp_normalize_round.md
FP_NORMALIZE_ROUND -- requirements
Module: fp_normalize_round

Interface
REQ-001 The block SHALL have parameter EXP_W, default 10, the signed width of the incoming exponent.
REQ-002 The block SHALL have these ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input beat valid
- in_ready  output  1  block can accept a beat
- in_sign  input  1  product sign
- in_exp  input  EXP_W  signed biased exponent (expA+expB-127)
- in_mant  input  48  raw significand product; value = in_mant/2^46 * 2^(in_exp-127)
- in_shift  input  6  leading-zero count of in_mant plus 1 (1..49; 49 = all-zero)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_data  output  32  packed IEEE-754 binary32 result
- out_flags  output  4  {overflow, underflow, inexact, zero}
- out_count  output  16  results delivered since reset, wrapping

Function
REQ-003 A beat SHALL transfer on a cycle with valid and ready both high, at input and at output.
REQ-004 Stage 1 SHALL do the following for an accepted beat:
- lz = in_shift-1
- norm = in_mant << lz
- e1 = in_exp + 1 - lz, computed in EXP_W+1 signed bits
REQ-005 Stage 2 SHALL round to nearest, ties to even:
- mantissa = norm[47:24], guard = norm[23], sticky = OR(norm[22:0])
- round up when guard & (sticky | mantissa[0])
REQ-006 A rounding carry out of 24 bits SHALL make the mantissa 0x800000 and increment the exponent.
REQ-007 Packing SHALL be {sign, e[7:0], mantissa[22:0]}; inexact SHALL be guard|sticky.
REQ-008 If the final exponent is >= 255, the result SHALL be signed infinity ({sign,0xFF,0}) with flags overflow=1, inexact=1.
REQ-009 If the final exponent is <= 0, the result SHALL be signed zero with underflow=1 and inexact=1 (flush; no subnormals).
REQ-010 An in_shift of 49, 0 or 50..63 SHALL produce signed zero with zero=1 and all other flags 0.
REQ-011 With out_ready held high, latency SHALL be exactly 2 cycles: accept at cycle N, out_valid at N+2. Throughput SHALL be one beat per cycle.
REQ-012 Pipeline control SHALL be elastic with registered valids s1_v and s2_v:
- stage 2 loads when !s2_v | out_ready
- stage 1 loads when !s1_v | stage-2 load
- in_ready = !s1_v | stage-2 load
REQ-013 out_data, out_flags and out_valid SHALL hold stable while out_valid & !out_ready.
REQ-014 Beats SHALL leave in acceptance order, with no loss and no duplication.
REQ-015 Simultaneous input accept and output drain with both stages full SHALL sustain one beat per cycle without a bubble.
REQ-016 out_count SHALL increment on each output transfer and wrap from 0xFFFF to 0x0000.

Reset
REQ-017 rst_n low SHALL asynchronously clear s1_v, s2_v, out_valid, out_data, out_flags and out_count to 0.
REQ-018 While rst_n is low, in_ready SHALL be 0; it SHALL be 1 on the first clock edge after release.
REQ-019 Beats in flight at reset SHALL be discarded and never emitted.

Structure
REQ-020 A shared package SHALL hold:
- FP32 constants: bias 127, EXP_MAX 255, infinity exponent 0xFF
- the flag bit indices
- the zero-code threshold 49
REQ-021 The round-and-pack logic SHALL be one combinational sub-module, fp32_round_pack. Pipeline registers and handshake SHALL stay in the top module.

Verification
REQ-022 1.0*1.0: in_mant=0x400000000000, in_exp=127, in_shift=2, sign=0 -> out_data=0x3F800000, flags=0, exactly 2 cycles later.
REQ-023 1.5*1.5: in_mant=0x900000000000, in_exp=127, in_shift=1 -> out_data=0x40100000, flags=0.
REQ-024 Rounding:
- tie-even: in_mant=0x800000800000, in_exp=127, in_shift=1 -> out_data=0x40000000, inexact=1
- tie-odd: in_mant=0x800001800000, in_exp=127, in_shift=1 -> out_data=0x40000002, inexact=1
REQ-025 Limits:
- in_exp=300, in_shift=1, sign=1 -> 0xFF800000, overflow=1
- in_exp=-20 -> 0x00000000, underflow=1
- in_mant=0, in_shift=49 -> zero=1
REQ-026 Backpressure: out_ready=0 for 6 cycles while in_valid=1 with 4 distinct beats.
- in_ready SHALL drop after 2 accepts.
- out_data SHALL be stable while stalled.
- all 4 results SHALL emerge in order.
- out_count SHALL be 4.
REQ-027 Reset mid-stream: assert rst_n=0 with both stages full -> outputs SHALL be 0 immediately, and no stale result SHALL appear after release.
